// File: rtl/collatz_range.sv
// Sweeps consecutive Collatz start values through an external iterator and
// records the step count of each in a result memory.
module collatz_range #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [31:0]              start,
  input  logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [CNT_W-1:0]         max_steps,
  output logic [31:0]              max_start,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [CNT_W-1:0]         rdata,
  output logic                     col_go,
  output logic [31:0]              col_n,
  input  logic [31:0]              col_dout,
  input  logic                     col_done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [AW:0]      DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    IDX_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] STEP_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT      = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [31:0]      r_start;
  logic [AW:0]      r_count;
  logic [AW-1:0]    r_idx;
  logic [CNT_W-1:0] r_steps;
  logic             r_overflow;
  logic [CNT_W-1:0] r_maxSteps;
  logic [31:0]      r_maxStart;
  logic [CNT_W-1:0] r_rdata;
  logic [CNT_W-1:0] r_mem [DEPTH];

  logic [AW:0]      w_clamped;
  logic [31:0]      w_curN;
  logic             w_finished;
  logic             w_sat;
  logic             w_write;
  logic [CNT_W-1:0] w_wval;
  logic             w_last;

  assign w_clamped = (count > DEPTH_C) ? DEPTH_C : count;
  assign w_curN    = r_start + {{(32-AW){1'b0}}, r_idx};
  // A value of 1 on the iterator output also ends the trajectory, so a
  // late done flag from the iterator cannot inflate the count.
  assign w_finished = col_done | (col_dout == 32'd1);
  assign w_sat      = (r_steps == SAT);
  assign w_write    = (r_state == S_RUN) && (w_finished || w_sat);
  assign w_wval     = w_finished ? r_steps : SAT;
  assign w_last     = ({1'b0, r_idx} == (r_count - CNT_ONE));

  assign busy      = (r_state == S_LOAD) || (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign overflow  = r_overflow;
  assign max_steps = r_maxSteps;
  assign max_start = r_maxStart;
  assign rdata     = r_rdata;
  assign col_go    = (r_state == S_LOAD);
  assign col_n     = w_curN;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_start    <= 32'd0;
      r_count    <= '0;
      r_idx      <= '0;
      r_steps    <= '0;
      r_overflow <= 1'b0;
      r_maxSteps <= '0;
      r_maxStart <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (go) begin
            r_start    <= start;
            r_count    <= w_clamped;
            r_idx      <= '0;
            r_steps    <= '0;
            r_overflow <= 1'b0;
            r_maxSteps <= '0;
            r_maxStart <= 32'd0;
            r_state    <= (w_clamped == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          r_steps <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_write) begin
            if (!w_finished) begin
              r_overflow <= 1'b1;
            end
            // Strictly greater keeps the earliest start on ties.
            if (w_wval > r_maxSteps) begin
              r_maxSteps <= w_wval;
              r_maxStart <= w_curN;
            end
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + IDX_ONE;
              r_state <= S_LOAD;
            end
          end else begin
            r_steps <= r_steps + STEP_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result memory is never reset; the read port returns pre-write data.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_idx] <= w_wval;
    end
    r_rdata <= r_mem[raddr];
  end

endmodule

// File: tb/tb_collatz_range.sv
// Directed bench for collatz_range: two instances (16-bit and 8-bit counters)
// each driven by a behavioural Collatz iterator.
module tb_collatz_range;

  logic clk;
  int   nChecks = 0;
  int   nFail   = 0;

  // Instance A: DEPTH=256, CNT_W=16
  logic        resetA, goA, busyA, doneA, overflowA, colGoA, colDoneA;
  logic [31:0] startA, maxStartA, colNA, colDoutA;
  logic [8:0]  countA;
  logic [15:0] maxStepsA, rdataA;
  logic [7:0]  raddrA;
  logic [31:0] curA = 32'd0;
  int          loadsA = 0;

  // Instance B: DEPTH=4, CNT_W=8
  logic        resetB, goB, busyB, doneB, overflowB, colGoB, colDoneB;
  logic [31:0] startB, maxStartB, colNB, colDoutB;
  logic [2:0]  countB;
  logic [7:0]  maxStepsB, rdataB;
  logic [1:0]  raddrB;
  logic [31:0] curB = 32'd0;

  collatz_range #(.DEPTH(256), .CNT_W(16)) dutA (
    .clk(clk), .reset(resetA), .go(goA), .start(startA), .count(countA),
    .busy(busyA), .done(doneA), .overflow(overflowA),
    .max_steps(maxStepsA), .max_start(maxStartA),
    .raddr(raddrA), .rdata(rdataA),
    .col_go(colGoA), .col_n(colNA), .col_dout(colDoutA), .col_done(colDoneA)
  );

  collatz_range #(.DEPTH(4), .CNT_W(8)) dutB (
    .clk(clk), .reset(resetB), .go(goB), .start(startB), .count(countB),
    .busy(busyB), .done(doneB), .overflow(overflowB),
    .max_steps(maxStepsB), .max_start(maxStartB),
    .raddr(raddrB), .rdata(rdataB),
    .col_go(colGoB), .col_n(colNB), .col_dout(colDoutB), .col_done(colDoneB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural iterators: load on col_go, then one Collatz step per edge until 1.
  always @(posedge clk) begin
    if (colGoA) curA <= colNA;
    else if (curA > 32'd1) curA <= curA[0] ? (32'd3 * curA + 32'd1) : (curA >> 1);
    if (colGoA) loadsA <= loadsA + 1;
  end
  assign colDoutA = curA;
  assign colDoneA = (curA <= 32'd1);

  always @(posedge clk) begin
    if (colGoB) curB <= colNB;
    else if (curB > 32'd1) curB <= curB[0] ? (32'd3 * curB + 32'd1) : (curB >> 1);
  end
  assign colDoutB = curB;
  assign colDoneB = (curB <= 32'd1);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse go on instance A for one edge; returns just after the go edge.
  task automatic applyStimulus(input logic [31:0] s, input logic [8:0] c);
    startA = s;
    countA = c;
    goA    = 1'b1;
    @(negedge clk);
    goA    = 1'b0;
  endtask

  task automatic waitDoneA(input int limit, output int edges);
    edges = 0;
    while (!doneA && edges < limit) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic readA(input logic [7:0] addr, output logic [15:0] data);
    raddrA = addr;
    @(negedge clk);
    data = rdataA;
  endtask

  initial begin
    int          edges;
    int          gaps;
    int          base;
    logic [15:0] rd;
    logic [15:0] expA [4];
    expA[0] = 16'd0; expA[1] = 16'd1; expA[2] = 16'd7; expA[3] = 16'd2;

    resetA = 1'b1; goA = 1'b0; startA = 32'd0; countA = 9'd0; raddrA = 8'd0;
    resetB = 1'b1; goB = 1'b0; startB = 32'd0; countB = 3'd0; raddrB = 2'd0;
    @(negedge clk);
    @(negedge clk);
    resetA = 1'b0;
    resetB = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_busy", busyA, 1'b0);
    checkOutput("rst_done", doneA, 1'b0);
    checkOutput("rst_overflow", overflowA, 1'b0);
    checkOutput("rst_max_steps", maxStepsA, 16'd0);
    checkOutput("rst_max_start", maxStartA, 32'd0);
    checkOutput("rst_col_go", colGoA, 1'b0);

    $display("[TB] start=1 count=4");
    applyStimulus(32'd1, 9'd4);
    checkOutput("s1_load_busy", busyA, 1'b1);
    checkOutput("s1_load_col_go", colGoA, 1'b1);
    checkOutput("s1_load_col_n", colNA, 32'd1);
    waitDoneA(200, edges);
    checkOutput("s1_done", doneA, 1'b1);
    checkOutput("s1_max_steps", maxStepsA, 16'd7);
    checkOutput("s1_max_start", maxStartA, 32'd3);
    checkOutput("s1_overflow", overflowA, 1'b0);
    for (int i = 0; i < 4; i++) begin
      readA(8'(i), rd);
      checkOutput($sformatf("s1_mem%0d", i), rd, expA[i]);
    end

    $display("[TB] start=27 count=1 latency");
    applyStimulus(32'd27, 9'd1);
    gaps = 0;
    edges = 0;
    while (!doneA && edges < 400) begin
      if (!busyA) gaps++;
      @(negedge clk);
      edges++;
    end
    checkOutput("s27_latency", edges, 113);
    checkOutput("s27_busy_gaps", gaps, 0);
    readA(8'd0, rd);
    checkOutput("s27_mem0", rd, 16'd111);
    checkOutput("s27_max_start", maxStartA, 32'd27);

    $display("[TB] count=0");
    base = loadsA;
    applyStimulus(32'd5, 9'd0);
    checkOutput("c0_done_next_edge", doneA, 1'b1);
    checkOutput("c0_busy", busyA, 1'b0);
    checkOutput("c0_max_steps", maxStepsA, 16'd0);
    checkOutput("c0_loads", loadsA - base, 0);
    readA(8'd0, rd);
    checkOutput("c0_mem0_kept", rd, 16'd111);

    $display("[TB] count=DEPTH+1 clamps to DEPTH");
    base = loadsA;
    applyStimulus(32'd1, 9'd257);
    waitDoneA(40000, edges);
    checkOutput("cmax_done", doneA, 1'b1);
    checkOutput("cmax_loads", loadsA - base, 256);
    readA(8'd26, rd);
    checkOutput("cmax_mem26", rd, 16'd111);
    readA(8'd255, rd);
    checkOutput("cmax_mem255", rd, 16'd8);

    $display("[TB] max tie-break sweeps");
    applyStimulus(32'd5, 9'd2);
    waitDoneA(200, edges);
    checkOutput("t1_max_steps", maxStepsA, 16'd8);
    checkOutput("t1_max_start", maxStartA, 32'd6);
    applyStimulus(32'd2, 9'd2);
    waitDoneA(200, edges);
    checkOutput("t2_max_steps", maxStepsA, 16'd7);
    checkOutput("t2_max_start", maxStartA, 32'd3);
    repeat (5) @(negedge clk);
    checkOutput("t2_done_held", doneA, 1'b1);
    checkOutput("t2_max_held", maxStepsA, 16'd7);

    $display("[TB] go ignored mid-RUN, then reset mid-RUN");
    applyStimulus(32'd27, 9'd1);
    repeat (20) @(negedge clk);
    applyStimulus(32'd1, 9'd1);
    repeat (10) @(negedge clk);
    checkOutput("midgo_busy", busyA, 1'b1);
    checkOutput("midgo_done", doneA, 1'b0);
    resetA = 1'b1;
    @(negedge clk);
    resetA = 1'b0;
    checkOutput("midrst_busy", busyA, 1'b0);
    checkOutput("midrst_col_go", colGoA, 1'b0);
    checkOutput("midrst_done", doneA, 1'b0);
    applyStimulus(32'd3, 9'd1);
    waitDoneA(200, edges);
    checkOutput("postrst_done", doneA, 1'b1);
    readA(8'd0, rd);
    checkOutput("postrst_mem0", rd, 16'd7);
    checkOutput("postrst_max_start", maxStartA, 32'd3);

    $display("[TB] CNT_W=8 saturation");
    startB = 32'd77031;
    countB = 3'd1;
    goB    = 1'b1;
    @(negedge clk);
    goB    = 1'b0;
    edges  = 0;
    while (!doneB && edges < 1000) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("sat_done", doneB, 1'b1);
    checkOutput("sat_latency", edges, 257);
    checkOutput("sat_overflow", overflowB, 1'b1);
    checkOutput("sat_max_steps", maxStepsB, 8'd255);
    raddrB = 2'd0;
    @(negedge clk);
    checkOutput("sat_mem0", rdataB, 8'd255);

    startB = 32'd3;
    countB = 3'd2;
    goB    = 1'b1;
    @(negedge clk);
    goB    = 1'b0;
    edges  = 0;
    while (!doneB && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("b2_done", doneB, 1'b1);
    checkOutput("b2_overflow_cleared", overflowB, 1'b0);
    raddrB = 2'd1;
    @(negedge clk);
    checkOutput("b2_mem1", rdataB, 8'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/collatz_range.md
COLLATZ_RANGE -- requirements
Module: collatz_range

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the result-memory entry count (power of two, >=2).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the step-count width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port go, input, 1 bit: start a sweep; sampled only in IDLE or DONE.
REQ-006 The block SHALL have port start, input, 32 bits: first start value of the sweep; sampled with go.
REQ-007 The block SHALL have port count, input, $clog2(DEPTH)+1 bits: number of consecutive start values; sampled with go.
REQ-008 The block SHALL have port busy, output, 1 bit: high in LOAD and RUN.
REQ-009 The block SHALL have port done, output, 1 bit: high in DONE.
REQ-010 The block SHALL have port overflow, output, 1 bit: sticky; high if any entry saturated during the current sweep.
REQ-011 The block SHALL have port max_steps, output, CNT_W bits: largest stored step count in the current sweep.
REQ-012 The block SHALL have port max_start, output, 32 bits: start value that produced max_steps.
REQ-013 The block SHALL have port raddr, input, $clog2(DEPTH) bits: result read address.
REQ-014 The block SHALL have port rdata, output, CNT_W bits: registered result data.
REQ-015 The block SHALL have port col_go, output, 1 bit: drives the iterator's go.
REQ-016 The block SHALL have port col_n, output, 32 bits: drives the iterator's n.
REQ-017 The block SHALL have port col_dout, input, 32 bits: the iterator's current value.
REQ-018 The block SHALL have port col_done, input, 1 bit: the iterator's done flag.

Function
REQ-019 The block SHALL implement states IDLE, LOAD, RUN and DONE.
REQ-020 IDLE/DONE with go=1 SHALL latch start, latch min(count,DEPTH), clear idx, steps, max_steps, max_start and overflow, and go to LOAD; if the clamped count is 0, it SHALL go to DONE instead with no writes.
REQ-021 LOAD SHALL assert col_go=1 with col_n=start+idx (mod 2^32) for exactly one cycle, clear steps, and go to RUN.
REQ-022 col_go SHALL be 0 in every state other than LOAD, and col_n SHALL be don't-care outside LOAD.
REQ-023 RUN with col_done=0 and steps<2^CNT_W-1 SHALL increment steps.
REQ-024 RUN with col_done=1 SHALL write steps to mem[idx].
REQ-025 RUN with col_done=0 and steps=2^CNT_W-1 SHALL write 2^CNT_W-1 to mem[idx] and set overflow.
REQ-026 After any write in RUN, the block SHALL go to DONE if idx was the last entry; otherwise it SHALL increment idx and go to LOAD.
REQ-027 The stored value SHALL equal the number of iterator steps to reach 1 (n=1 -> 0, n=2 -> 1, n=3 -> 7, n=0 -> 0).
REQ-028 Per-value latency SHALL be steps+2 clock edges (one LOAD edge plus steps+1 RUN edges).
REQ-029 done SHALL rise on the edge of the final write.
REQ-030 On each write, max_steps and max_start SHALL update only if the written value is strictly greater than max_steps (the earliest start wins ties).
REQ-031 go SHALL be ignored in LOAD and RUN.
REQ-032 DONE SHALL hold all outputs until go or reset.
REQ-033 rdata SHALL equal mem[raddr] one cycle after raddr is presented; reads are legal in any state.
REQ-034 A same-cycle read and write to one address SHALL return the old data.

Reset
REQ-035 reset=1 SHALL force IDLE at the next edge from any state, including mid-RUN.
REQ-036 reset SHALL clear busy, done, overflow, max_steps, max_start, idx, steps and col_go to 0.
REQ-037 reset SHALL take priority over go.
REQ-038 Memory contents and rdata SHALL NOT be reset.

Verification
REQ-039 Bench SHALL cover: start=1, count=4 -> mem[0..3]=0,1,7,2; max_steps=7; max_start=3; overflow=0.
REQ-040 Bench SHALL cover: start=27, count=1 -> done rises 113 edges after the go edge; mem[0]=111; busy high in between.
REQ-041 Bench SHALL cover: count=0 -> done on the next edge, no memory writes, max_steps=0; count=DEPTH+1 -> exactly DEPTH entries written.
REQ-042 Bench SHALL cover: CNT_W=8, start=77031, count=1 -> mem[0]=255; overflow=1; done asserted.
REQ-043 Bench SHALL cover: go pulsed mid-RUN -> ignored; then reset mid-RUN -> IDLE next edge with busy=0 and col_go=0; a new go after reset runs normally.
REQ-044 Bench SHALL cover: start=5, count=2 (results 5, 8) -> max_start=6; after a sweep with start=2, count=2 (results 1, 7) -> max_start=3.
